// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register, req/ack instruction fetch and IF/ID register with stall, redirect flush and in-flight discard
module if_fetch_unit #(
    parameter int                  bitwidth = 32,
    parameter logic [bitwidth-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [bitwidth-1:0] next_pc,
    input  logic                redirect,
    input  logic                stall,
    output logic [bitwidth-1:0] pc_plus4,
    output logic                imem_req,
    output logic [bitwidth-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [bitwidth-1:0] imem_rdata,
    output logic [bitwidth-1:0] pc_out,
    output logic [bitwidth-1:0] instr_out,
    output logic                valid_out
);
    typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} state_t;
    state_t              state_q, state_d;
    logic [bitwidth-1:0] pc_q, pc_d, fa_q, fa_d;
    logic [bitwidth-1:0] pc_out_q, pc_out_d, instr_q, instr_d;
    logic [bitwidth-1:0] buf_pc_q, buf_pc_d, buf_instr_q, buf_instr_d;
    logic                valid_q, valid_d;

    assign pc_plus4  = pc_q + bitwidth'(4);
    assign imem_req  = (state_q == REQ) || (state_q == DROP);
    assign imem_addr = fa_q;
    assign pc_out    = pc_out_q;
    assign instr_out = instr_q;
    assign valid_out = valid_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fa_d        = fa_q;
        pc_out_d    = pc_out_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redirect) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    if (imem_ack) fa_d = next_pc;
                    else state_d = DROP;
                end else if (imem_ack) begin
                    pc_d = next_pc;
                    fa_d = next_pc;
                    if (stall) begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem_rdata;
                        state_d     = HOLD;
                    end else begin
                        pc_out_d = pc_q;
                        instr_d  = imem_rdata;
                        valid_d  = 1'b1;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            DROP: begin
                // the stale response is consumed here; refetch from the latest pc
                if (redirect) pc_d = next_pc;
                if (imem_ack) begin
                    fa_d    = redirect ? next_pc : pc_q;
                    state_d = REQ;
                end
                if (redirect || !stall) valid_d = 1'b0;
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = next_pc;
                    fa_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = REQ;
                end else if (!stall) begin
                    pc_out_d = buf_pc_q;
                    instr_d  = buf_instr_q;
                    valid_d  = 1'b1;
                    state_d  = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            fa_q        <= RESET_PC;
            pc_out_q    <= '0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fa_q        <= fa_d;
            pc_out_q    <= pc_out_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios for if_fetch_unit with hand-computed IF/ID and fetch-address expectations
module tb_if_fetch_unit;
    localparam logic [31:0] K = 32'hA5A5_0000;
    logic        clk = 0, rst_n = 0, redirect = 0, stall = 0, ack = 0;
    logic [31:0] target = 0;
    logic [31:0] next_pc, pc_plus4, addr, rdata, pc_out, instr_out;
    logic        req, valid;
    logic [31:0] next_pc2, pc_plus4_2, addr2, rdata2, pc_out2, instr_out2;
    logic        req2, valid2;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    // environment: next-PC mux and a memory whose word is address^K
    assign next_pc  = redirect ? target : pc_plus4;
    assign next_pc2 = redirect ? target : pc_plus4_2;
    assign rdata    = addr ^ K;
    assign rdata2   = addr2 ^ K;

    if_fetch_unit #(.bitwidth(32), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .redirect(redirect), .stall(stall),
        .pc_plus4(pc_plus4), .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
        .pc_out(pc_out), .instr_out(instr_out), .valid_out(valid));

    if_fetch_unit #(.bitwidth(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .next_pc(next_pc2), .redirect(redirect), .stall(stall),
        .pc_plus4(pc_plus4_2), .imem_req(req2), .imem_addr(addr2), .imem_ack(ack), .imem_rdata(rdata2),
        .pc_out(pc_out2), .instr_out(instr_out2), .valid_out(valid2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; ack = 0; stall = 0; redirect = 0;
        step(); step();
        tests++;
        if ({req, addr, valid, pc_out, instr_out, pc_plus4} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4}) begin
            $display("FAIL reset: got req=%b addr=%h v=%b pc=%h ins=%h p4=%h exp 0 0 0 0 0 4",
                     req, addr, valid, pc_out, instr_out, pc_plus4);
            fails++;
        end
    endtask

    task automatic test_sequential();
        rst_n = 1;
        step();
        tests++;
        if ({req, addr, valid} !== {1'b1, 32'h0, 1'b0}) begin
            $display("FAIL seq_first_req: got req=%b addr=%h v=%b exp 1 0 0", req, addr, valid);
            fails++;
        end
        ack = 1;
        for (int i = 1; i <= 4; i++) begin
            step();
            tests++;
            if ({req, addr, valid, pc_out, instr_out} !==
                {1'b1, 32'(4*i), 1'b1, 32'(4*(i-1)), 32'(4*(i-1)) ^ K}) begin
                $display("FAIL seq_%0d: got addr=%h v=%b pc=%h ins=%h exp addr=%h pc=%h",
                         i, addr, valid, pc_out, instr_out, 4*i, 4*(i-1));
                fails++;
            end
        end
    endtask

    task automatic test_delayed_ack();
        logic [31:0] a;
        a = 32'h10;
        for (int f = 0; f < 2; f++) begin
            ack = 0;
            for (int w = 0; w < 3; w++) begin
                step();
                tests++;
                if ({req, addr, valid} !== {1'b1, a, 1'b0}) begin
                    $display("FAIL delay_wait_%0d_%0d: got req=%b addr=%h v=%b exp 1 %h 0", f, w, req, addr, valid, a);
                    fails++;
                end
            end
            ack = 1;
            step();
            tests++;
            if ({addr, valid, pc_out, instr_out} !== {a + 32'h4, 1'b1, a, a ^ K}) begin
                $display("FAIL delay_ack_%0d: got addr=%h v=%b pc=%h ins=%h exp %h 1 %h %h",
                         f, addr, valid, pc_out, instr_out, a + 4, a, a ^ K);
                fails++;
            end
            a = a + 4;
        end
    endtask

    task automatic test_stall_hold();
        stall = 1; ack = 1;
        step();
        ack = 0;
        for (int c = 0; c < 4; c++) begin
            tests++;
            if ({req, addr, valid, pc_out} !== {1'b0, 32'h1C, 1'b1, 32'h14}) begin
                $display("FAIL hold_%0d: got req=%b addr=%h v=%b pc=%h exp 0 1c 1 14", c, req, addr, valid, pc_out);
                fails++;
            end
            if (c < 3) step();
        end
        stall = 0;
        step();
        tests++;
        if ({req, addr, valid, pc_out, instr_out} !== {1'b1, 32'h1C, 1'b1, 32'h18, 32'h18 ^ K}) begin
            $display("FAIL hold_release: got req=%b addr=%h v=%b pc=%h ins=%h exp 1 1c 1 18 %h",
                     req, addr, valid, pc_out, instr_out, 32'h18 ^ K);
            fails++;
        end
    endtask

    task automatic test_redirect_drop();
        step();
        redirect = 1; target = 32'h100;
        step();
        redirect = 0;
        tests++;
        if ({req, addr, valid} !== {1'b1, 32'h1C, 1'b0}) begin
            $display("FAIL drop_enter: got req=%b addr=%h v=%b exp 1 1c 0", req, addr, valid);
            fails++;
        end
        step();
        tests++;
        if ({req, addr} !== {1'b1, 32'h1C}) begin
            $display("FAIL drop_wait: got req=%b addr=%h exp 1 1c", req, addr);
            fails++;
        end
        ack = 1;
        step();
        tests++;
        if ({req, addr, valid} !== {1'b1, 32'h100, 1'b0}) begin
            $display("FAIL drop_ack: got req=%b addr=%h v=%b exp 1 100 0", req, addr, valid);
            fails++;
        end
        step();
        tests++;
        if ({addr, valid, pc_out, instr_out} !== {32'h104, 1'b1, 32'h100, 32'h100 ^ K}) begin
            $display("FAIL drop_refetch: got addr=%h v=%b pc=%h ins=%h exp 104 1 100", addr, valid, pc_out, instr_out);
            fails++;
        end
    endtask

    task automatic test_redirect_corner();
        redirect = 1; target = 32'h200; ack = 1;
        step();
        redirect = 0;
        tests++;
        if ({req, addr, valid} !== {1'b1, 32'h200, 1'b0}) begin
            $display("FAIL redir_ack: got req=%b addr=%h v=%b exp 1 200 0", req, addr, valid);
            fails++;
        end
        step();
        tests++;
        if ({addr, valid, pc_out} !== {32'h204, 1'b1, 32'h200}) begin
            $display("FAIL redir_ack_next: got addr=%h v=%b pc=%h exp 204 1 200", addr, valid, pc_out);
            fails++;
        end
        stall = 1;
        step();
        ack = 0;
        step();
        redirect = 1; target = 32'h300;
        step();
        redirect = 0;
        tests++;
        if ({req, addr, valid} !== {1'b1, 32'h300, 1'b0}) begin
            $display("FAIL redir_hold: got req=%b addr=%h v=%b exp 1 300 0", req, addr, valid);
            fails++;
        end
        stall = 0; ack = 1;
        step();
        tests++;
        if ({valid, pc_out, instr_out} !== {1'b1, 32'h300, 32'h300 ^ K}) begin
            $display("FAIL redir_hold_next: got v=%b pc=%h ins=%h exp 1 300 %h", valid, pc_out, instr_out, 32'h300 ^ K);
            fails++;
        end
    endtask

    task automatic test_wrap_and_reset();
        rst_n = 0; ack = 0; stall = 0; redirect = 0;
        step();
        tests++;
        if ({req2, addr2, pc_plus4_2} !== {1'b0, 32'hFFFF_FFFC, 32'h0}) begin
            $display("FAIL wrap_reset: got req=%b addr=%h p4=%h exp 0 fffffffc 0", req2, addr2, pc_plus4_2);
            fails++;
        end
        rst_n = 1; ack = 1;
        step();
        step();
        tests++;
        if ({addr2, valid2, pc_out2} !== {32'h0, 1'b1, 32'hFFFF_FFFC}) begin
            $display("FAIL wrap_fetch: got addr=%h v=%b pc=%h exp 0 1 fffffffc", addr2, valid2, pc_out2);
            fails++;
        end
        ack = 0;
        step();
        redirect = 1; target = 32'h400;
        step();
        redirect = 0;
        tests++;
        if ({req, addr, valid} !== {1'b1, 32'h4, 1'b0}) begin
            $display("FAIL mid_drop: got req=%b addr=%h v=%b exp 1 4 0", req, addr, valid);
            fails++;
        end
        rst_n = 0; ack = 1;
        step();
        tests++;
        if ({req, addr, valid, pc_out, instr_out, pc_plus4} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4}) begin
            $display("FAIL drop_reset: got req=%b addr=%h v=%b pc=%h ins=%h p4=%h exp 0 0 0 0 0 4",
                     req, addr, valid, pc_out, instr_out, pc_plus4);
            fails++;
        end
        rst_n = 1; ack = 0;
        step();
        ack = 1;
        step();
        tests++;
        if ({addr, valid, pc_out, instr_out} !== {32'h4, 1'b1, 32'h0, K}) begin
            $display("FAIL post_reset_fetch: got addr=%h v=%b pc=%h ins=%h exp 4 1 0 %h", addr, valid, pc_out, instr_out, K);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_delayed_ack();
        test_stall_hold();
        test_redirect_drop();
        test_redirect_corner();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
